// File: rtl/tm1638_display_arbiter.sv
// tm1638_display_arbiter
// Collects display frames (64 segment bits + 8 LED bits) from several
// producers, keeps the newest frame per producer, and hands them one at a
// time to a TM1638 driver using round-robin arbitration. After each issue the
// arbiter waits for the driver to report busy and then idle again (or for an
// acknowledge timeout), optionally enforces an idle gap, and only then grants
// the next pending frame.

module tm1638_display_arbiter #(
    parameter int NUM_SRC        = 2,
    parameter int MIN_GAP_CYCLES = 0,
    parameter int ACK_TIMEOUT    = 15
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic [NUM_SRC*64-1:0] i_Segments,
    input  logic [NUM_SRC*8-1:0] i_Leds,
    input  logic [NUM_SRC-1:0]   i_Valid,
    input  logic                 i_Busy,
    output logic [63:0]          o_Segments,
    output logic [7:0]           o_Leds,
    output logic                 o_Valid,
    output logic [NUM_SRC-1:0]   o_Grant,
    output logic [NUM_SRC-1:0]   o_Drop,
    output logic                 o_Timeout
);

    localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    // One shared counter serves both the acknowledge timeout and the gap;
    // sized for the larger of the two plus headroom so it never wraps.
    localparam int CNT_MAX = (ACK_TIMEOUT > MIN_GAP_CYCLES) ? ACK_TIMEOUT : MIN_GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((MIN_GAP_CYCLES > 0) ? MIN_GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    // Per-source views of the flattened input buses
    logic [63:0] src_seg [NUM_SRC];
    logic [7:0]  src_led [NUM_SRC];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_seg[gi] = i_Segments[gi*64 +: 64];
            assign src_led[gi] = i_Leds[gi*8 +: 8];
        end
    endgenerate

    // Frame buffers and bookkeeping
    logic [63:0]        seg_buf_q [NUM_SRC];
    logic [7:0]         led_buf_q [NUM_SRC];
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] drop_q;
    logic [IDX_W-1:0]   rr_q;

    // Registered driver-facing outputs
    logic [63:0]        seg_out_q;
    logic [7:0]         led_out_q;
    logic [NUM_SRC-1:0] grant_q;
    logic               valid_q;
    logic               timeout_q;

    // FSM state and shared cycle counter
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               grant_now;
    logic               timeout_d;

    // Arbitration result
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_SRC-1:0] pick_onehot;
    logic [NUM_SRC-1:0] issue_vec;

    // Round-robin search: first pending source at or after the pointer
    always_comb begin
        int cand;
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        cand        = 0;
        for (int off = 0; off < NUM_SRC; off++) begin
            cand = int'(rr_q) + off;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!pick_found && pend_q[cand]) begin
                pick_found        = 1'b1;
                pick_idx          = IDX_W'(cand);
                pick_onehot[cand] = 1'b1;
            end
        end
    end

    assign issue_vec = grant_now ? pick_onehot : '0;

    // Next-state logic for the issue/acknowledge/done/gap handshake
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_now = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_found && !i_Busy) begin
                    grant_now = 1'b1;
                    state_d   = S_WAIT_ACK;
                    cnt_d     = '0;
                end
            end
            S_WAIT_ACK: begin
                if (i_Busy) begin
                    state_d = S_WAIT_DONE;
                    cnt_d   = '0;
                end else if (cnt_q == ACK_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = (MIN_GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!i_Busy) begin
                    state_d = (MIN_GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Frame capture, pending/drop tracking and output loading on grant.
    // A source strobing on its own grant edge gets its old frame issued and
    // the new one kept pending; that is not a drop.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                seg_buf_q[k] <= '0;
                led_buf_q[k] <= '0;
            end
            pend_q    <= '0;
            drop_q    <= '0;
            rr_q      <= '0;
            seg_out_q <= '0;
            led_out_q <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q   <= grant_now;
            timeout_q <= timeout_d;
            if (grant_now) begin
                seg_out_q <= seg_buf_q[pick_idx];
                led_out_q <= led_buf_q[pick_idx];
                grant_q   <= pick_onehot;
                rr_q      <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
            end
            for (int k = 0; k < NUM_SRC; k++) begin
                drop_q[k] <= i_Valid[k] & pend_q[k] & ~issue_vec[k];
                if (i_Valid[k]) begin
                    seg_buf_q[k] <= src_seg[k];
                    led_buf_q[k] <= src_led[k];
                    pend_q[k]    <= 1'b1;
                end else if (issue_vec[k]) begin
                    pend_q[k]    <= 1'b0;
                end
            end
        end
    end

    assign o_Segments = seg_out_q;
    assign o_Leds     = led_out_q;
    assign o_Valid    = valid_q;
    assign o_Grant    = grant_q;
    assign o_Drop     = drop_q;
    assign o_Timeout  = timeout_q;

endmodule

// File: tb/tb_tm1638_display_arbiter.sv
// Bench for tm1638_display_arbiter: a directed vector table, a gap-length
// sequence on a second instance with a minimum gap, and a randomized run
// compared against a frame-level reference model.

module tb_tm1638_display_arbiter;

    localparam int N   = 2;
    localparam int ACK = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic         rst;
    logic [127:0] segs;
    logic [15:0]  leds;
    logic [1:0]   vld;
    logic         busy;
    logic [63:0]  o_seg;
    logic [7:0]   o_led;
    logic         o_vld;
    logic [1:0]   o_gnt;
    logic [1:0]   o_drp;
    logic         o_to;

    tm1638_display_arbiter #(.NUM_SRC(N), .MIN_GAP_CYCLES(0), .ACK_TIMEOUT(ACK)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Segments(segs), .i_Leds(leds), .i_Valid(vld),
        .i_Busy(busy), .o_Segments(o_seg), .o_Leds(o_led), .o_Valid(o_vld),
        .o_Grant(o_gnt), .o_Drop(o_drp), .o_Timeout(o_to)
    );

    // Second instance with a 3-cycle gap
    logic         g_rst;
    logic [127:0] g_segs;
    logic [15:0]  g_leds;
    logic [1:0]   g_vld;
    logic         g_busy;
    logic [63:0]  g_oseg;
    logic [7:0]   g_oled;
    logic         g_ovld;
    logic [1:0]   g_ognt;
    logic [1:0]   g_odrp;
    logic         g_oto;

    tm1638_display_arbiter #(.NUM_SRC(N), .MIN_GAP_CYCLES(3), .ACK_TIMEOUT(ACK)) dut_gap (
        .i_Clk(clk), .i_Rst(g_rst), .i_Segments(g_segs), .i_Leds(g_leds), .i_Valid(g_vld),
        .i_Busy(g_busy), .o_Segments(g_oseg), .o_Leds(g_oled), .o_Valid(g_ovld),
        .o_Grant(g_ognt), .o_Drop(g_odrp), .o_Timeout(g_oto)
    );

    int errors = 0;
    int checks = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [77:0] act, input logic [77:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic        busy;
        logic [63:0] seg0;
        logic [63:0] seg1;
        logic [7:0]  led0;
        logic [7:0]  led1;
        logic        e_valid;
        logic [1:0]  e_grant;
        logic [63:0] e_seg;
        logic [7:0]  e_led;
        logic [1:0]  e_drop;
        logic        e_to;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [1:0] v, input logic b,
                                input logic [7:0] l0, input logic [7:0] l1,
                                input logic ev, input logic [1:0] eg, input logic [7:0] el,
                                input logic [1:0] ed, input logic et);
        vec_t x;
        x.rst = r; x.v = v; x.busy = b;
        x.led0 = l0; x.led1 = l1;
        x.seg0 = {8{l0}}; x.seg1 = {8{l1}};
        x.e_valid = ev; x.e_grant = eg; x.e_led = el; x.e_seg = {8{el}};
        x.e_drop = ed; x.e_to = et;
        vecs.push_back(x);
    endfunction

    // ---------------- reference model ----------------
    bit [1:0]    m_pend;
    logic [63:0] m_bseg [N];
    logic [7:0]  m_bled [N];
    bit          m_ready;     // arbiter may issue
    bit          m_acked;     // driver has shown busy for the frame in flight
    int          m_wait;      // cycles waited for acknowledge
    int          m_next;      // first source to consider next
    logic [63:0] e_seg;
    logic [7:0]  e_led;
    logic [1:0]  e_gnt;
    logic        e_vld;
    logic [1:0]  e_drop;
    logic        e_to;
    int          m_issued;

    function automatic void model_step(input logic r, input logic [1:0] v, input logic b,
                                       input logic [127:0] s, input logic [15:0] l);
        int g;
        if (r) begin
            m_pend = '0;
            for (int k = 0; k < N; k++) begin
                m_bseg[k] = '0;
                m_bled[k] = '0;
            end
            m_ready = 1; m_acked = 0; m_wait = 0; m_next = 0;
            e_seg = '0; e_led = '0; e_gnt = '0; e_vld = 0; e_drop = '0; e_to = 0;
            return;
        end
        g = -1;
        e_vld = 0; e_to = 0; e_drop = '0;
        if (m_ready) begin
            if (m_pend != 0 && !b) begin
                for (int off = 0; off < N; off++) begin
                    if (g < 0 && m_pend[(m_next + off) % N]) g = (m_next + off) % N;
                end
                e_seg = m_bseg[g];
                e_led = m_bled[g];
                e_gnt = 2'(1 << g);
                e_vld = 1;
                m_next = (g + 1) % N;
                m_ready = 0; m_acked = 0; m_wait = 0;
                m_issued++;
            end
        end else if (!m_acked) begin
            m_wait++;
            if (b) m_acked = 1;
            else if (m_wait == ACK) begin
                e_to = 1;
                m_ready = 1;
            end
        end else if (!b) begin
            m_ready = 1;
        end
        for (int k = 0; k < N; k++) begin
            if (v[k]) begin
                if (m_pend[k] && g != k) e_drop[k] = 1;
                m_bseg[k] = s[k*64 +: 64];
                m_bled[k] = l[k*8 +: 8];
                m_pend[k] = 1;
            end else if (g == k) begin
                m_pend[k] = 0;
            end
        end
    endfunction

    initial begin
        int n;
        int pbusy;
        int pvld;
        rst = 1; vld = '0; busy = 0; segs = '0; leds = '0;
        g_rst = 1; g_vld = '0; g_busy = 0; g_segs = '0; g_leds = '0;

        // Table rows: rst, v, busy, led0, led1 | valid, grant, leds, drop, timeout
        add(1, 2'b00, 0, 8'h00, 8'h00, 0, 2'b00, 8'h00, 2'b00, 0);  // 0 reset
        add(0, 2'b01, 0, 8'hA5, 8'h00, 0, 2'b00, 8'h00, 2'b00, 0);  // 1 capture src0
        add(0, 2'b00, 0, 8'h00, 8'h00, 1, 2'b01, 8'hA5, 2'b00, 0);  // 2 issue 2 edges later
        add(0, 2'b00, 0, 8'h00, 8'h00, 0, 2'b01, 8'hA5, 2'b00, 0);  // 3
        add(0, 2'b00, 1, 8'h00, 8'h00, 0, 2'b01, 8'hA5, 2'b00, 0);  // 4 busy
        add(0, 2'b00, 0, 8'h00, 8'h00, 0, 2'b01, 8'hA5, 2'b00, 0);  // 5 done
        add(1, 2'b00, 0, 8'h00, 8'h00, 0, 2'b00, 8'h00, 2'b00, 0);  // 6 reset
        add(0, 2'b11, 0, 8'h10, 8'h20, 0, 2'b00, 8'h00, 2'b00, 0);  // 7 both strobe
        add(0, 2'b00, 0, 8'h00, 8'h00, 1, 2'b01, 8'h10, 2'b00, 0);  // 8 src0 first
        add(0, 2'b00, 1, 8'h00, 8'h00, 0, 2'b01, 8'h10, 2'b00, 0);  // 9
        add(0, 2'b01, 0, 8'h30, 8'h00, 0, 2'b01, 8'h10, 2'b00, 0);  // 10 third frame src0
        add(0, 2'b00, 0, 8'h00, 8'h00, 1, 2'b10, 8'h20, 2'b00, 0);  // 11 src1
        add(0, 2'b10, 0, 8'h00, 8'h40, 0, 2'b10, 8'h20, 2'b00, 0);  // 12 second frame src1
        add(0, 2'b00, 1, 8'h00, 8'h00, 0, 2'b10, 8'h20, 2'b00, 0);  // 13
        add(0, 2'b00, 0, 8'h00, 8'h00, 0, 2'b10, 8'h20, 2'b00, 0);  // 14
        add(0, 2'b00, 0, 8'h00, 8'h00, 1, 2'b01, 8'h30, 2'b00, 0);  // 15 src0 before src1
        add(0, 2'b00, 1, 8'h00, 8'h00, 0, 2'b01, 8'h30, 2'b00, 0);  // 16
        add(0, 2'b00, 0, 8'h00, 8'h00, 0, 2'b01, 8'h30, 2'b00, 0);  // 17
        add(0, 2'b00, 0, 8'h00, 8'h00, 1, 2'b10, 8'h40, 2'b00, 0);  // 18
        add(0, 2'b10, 1, 8'h00, 8'h11, 0, 2'b10, 8'h40, 2'b00, 0);  // 19 src1 frame 11
        add(0, 2'b10, 1, 8'h00, 8'h22, 0, 2'b10, 8'h40, 2'b10, 0);  // 20 overwrite -> drop
        add(0, 2'b00, 1, 8'h00, 8'h00, 0, 2'b10, 8'h40, 2'b00, 0);  // 21 drop is one pulse
        add(0, 2'b00, 0, 8'h00, 8'h00, 0, 2'b10, 8'h40, 2'b00, 0);  // 22
        add(0, 2'b00, 0, 8'h00, 8'h00, 1, 2'b10, 8'h22, 2'b00, 0);  // 23 latest wins
        add(0, 2'b01, 0, 8'h55, 8'h00, 0, 2'b10, 8'h22, 2'b00, 0);  // 24 wait 1
        for (int i = 0; i < 13; i++)
            add(0, 2'b00, 0, 8'h00, 8'h00, 0, 2'b10, 8'h22, 2'b00, 0);  // 25..37
        add(0, 2'b00, 0, 8'h00, 8'h00, 0, 2'b10, 8'h22, 2'b00, 1);  // 38 timeout
        add(0, 2'b00, 0, 8'h00, 8'h00, 1, 2'b01, 8'h55, 2'b00, 0);  // 39 next frame
        add(0, 2'b00, 1, 8'h00, 8'h00, 0, 2'b01, 8'h55, 2'b00, 0);  // 40
        add(0, 2'b00, 0, 8'h00, 8'h00, 0, 2'b01, 8'h55, 2'b00, 0);  // 41
        add(0, 2'b01, 0, 8'h66, 8'h00, 0, 2'b01, 8'h55, 2'b00, 0);  // 42
        add(0, 2'b01, 0, 8'h77, 8'h00, 1, 2'b01, 8'h66, 2'b00, 0);  // 43 strobe on grant edge
        add(0, 2'b00, 1, 8'h00, 8'h00, 0, 2'b01, 8'h66, 2'b00, 0);  // 44 no drop
        add(0, 2'b00, 0, 8'h00, 8'h00, 0, 2'b01, 8'h66, 2'b00, 0);  // 45
        add(0, 2'b00, 0, 8'h00, 8'h00, 1, 2'b01, 8'h77, 2'b00, 0);  // 46 kept frame issued
        add(0, 2'b10, 1, 8'h00, 8'h99, 0, 2'b01, 8'h77, 2'b00, 0);  // 47 wait done, src1 pending
        add(1, 2'b11, 1, 8'hEE, 8'hEE, 0, 2'b00, 8'h00, 2'b00, 0);  // 48 reset mid transfer
        for (int i = 0; i < 4; i++)
            add(0, 2'b00, 0, 8'h00, 8'h00, 0, 2'b00, 8'h00, 2'b00, 0);  // 49..52 nothing issued
        vecs[1].seg0 = 64'h0123456789ABCDEF;
        for (int r = 2; r <= 5; r++) vecs[r].e_seg = 64'h0123456789ABCDEF;

        foreach (vecs[i]) begin
            rst  = vecs[i].rst;
            vld  = vecs[i].v;
            busy = vecs[i].busy;
            segs = {vecs[i].seg1, vecs[i].seg0};
            leds = {vecs[i].led1, vecs[i].led0};
            step();
            check($sformatf("row%0d", i),
                  {o_vld, o_gnt, o_seg, o_led, o_drp, o_to},
                  {vecs[i].e_valid, vecs[i].e_grant, vecs[i].e_seg, vecs[i].e_led,
                   vecs[i].e_drop, vecs[i].e_to});
            $display("row %0d: valid=%b grant=%b leds=%h drop=%b timeout=%b",
                     i, o_vld, o_gnt, o_led, o_drp, o_to);
        end

        // ---------------- gap sequence on the MIN_GAP_CYCLES=3 instance ----------------
        rst = 1; vld = '0; busy = 0;
        g_rst = 1; step();
        g_rst = 0; g_vld = 2'b11; g_leds = {8'hB2, 8'hB1}; g_segs = {{8{8'hB2}}, {8{8'hB1}}};
        step();
        g_vld = 2'b00;
        step();
        check("gap_first_issue", {g_ovld, g_ognt, g_oseg, g_oled, g_odrp, g_oto},
              {1'b1, 2'b01, {8{8'hB1}}, 8'hB1, 2'b00, 1'b0});
        $display("gap: first issue grant=%b leds=%h", g_ognt, g_oled);
        g_busy = 1; step();
        g_busy = 0; step();                    // busy seen low: gap begins
        n = 0;
        while (!g_ovld && n < 20) begin
            step();
            n++;
        end
        check("gap_cycles", 78'(n - 1), 78'(3));
        check("gap_second_issue", {g_ovld, g_ognt, g_oseg, g_oled, g_odrp, g_oto},
              {1'b1, 2'b10, {8{8'hB2}}, 8'hB2, 2'b00, 1'b0});
        $display("gap: second issue after %0d idle cycles grant=%b leds=%h", n - 1, g_ognt, g_oled);
        g_rst = 1;

        // ---------------- randomized run against the reference model ----------------
        m_issued = 0;
        pbusy = 0; pvld = 25;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                pbusy = (c / 250) % 3 == 0 ? 0 : ((c / 250) % 3 == 1 ? 40 : 80);
                pvld  = 10 + 10 * ((c / 250) % 4);
            end
            rst  = (c == 0) || ($urandom_range(0, 299) == 0);
            busy = ($urandom_range(0, 99) < pbusy);
            for (int k = 0; k < N; k++) vld[k] = ($urandom_range(0, 99) < pvld);
            segs = {$urandom, $urandom, $urandom, $urandom};
            leds = 16'($urandom);
            step();
            model_step(rst, vld, busy, segs, leds);
            check($sformatf("rand%0d", c),
                  {o_vld, o_gnt, o_seg, o_led, o_drp, o_to},
                  {e_vld, e_gnt, e_seg, e_led, e_drop, e_to});
            if (e_vld) $display("rand %0d: issue grant=%b leds=%h", c, e_gnt, e_led);
        end
        $display("random issues: %0d", m_issued);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
